video_mode_ctrl: RTL and testbench
==================================

Name: video_mode_ctrl

Overview:
Run-time video mode controller that sequences the pixel timing generator through resolution changes. It accepts mode-change requests on a valid/ready handshake and waits for a frame boundary before stopping the timing generator. It then requests a pixel-clock reconfiguration, loads the new timing parameters and re-enables the generator after a settle period. It sits between the host or control logic and the programmable timing generator / clocking wizard.

Parameters:
P_DEFAULT_MODE, 0, mode loaded after reset (0..2)
P_SETTLE_CYCLES, 16, cycles between clock ack and generator re-enable (>=1)
P_ACK_TIMEOUT, 1024, cycles to wait for i_clk_ack before error and retry (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_mode_valid  in  1  mode-change request valid
i_mode  in  2  requested mode: 0=640x480, 1=1280x720, 2=1920x1080, 3=invalid
o_mode_ready  out  1  controller can accept a request
i_frame_end  in  1  1-cycle pulse from timing generator on last pixel of frame
o_tg_en  out  1  timing generator enable (generator holds at x=y=0 when low)
o_res_x  out  12  active width
o_res_y  out  12  active height
o_hfront / o_hsync / o_hback  out  8 each  horizontal front porch / sync / back porch
o_vfront / o_vsync / o_vback  out  8 each  vertical front porch / sync / back porch
o_clk_sel  out  2  pixel clock select to clock reconfig block
o_clk_req  out  1  1-cycle reconfig request strobe
i_clk_ack  in  1  reconfig done / clock locked pulse
o_cur_mode  out  2  mode currently programmed
o_busy  out  1  high in any state other than RUN
o_err  out  1  1-cycle pulse: invalid mode request or ack timeout

Behaviour:
- Mode table (hfront/hsync/hback, vfront/vsync/vback):
  - 0: 640x480, 16/96/48, 10/2/33
  - 1: 1280x720, 110/40/220, 5/5/20
  - 2: 1920x1080, 88/44/148, 4/5/36
- All outputs registered.
- Reset values:
  - o_tg_en=0, o_mode_ready=0, o_clk_req=0, o_err=0, o_busy=1.
  - o_clk_sel=P_DEFAULT_MODE, o_cur_mode=P_DEFAULT_MODE, timing outputs = table[P_DEFAULT_MODE].
  - pending=P_DEFAULT_MODE; state=CLK_REQ.
- States:
  - RUN: o_tg_en=1, o_mode_ready=1, o_busy=0. A request is accepted when i_mode_valid is high in RUN (ready is high). On acceptance:
    - mode 3: o_err pulses next cycle; stay in RUN.
    - mode == o_cur_mode: no-op; stay in RUN.
    - otherwise: latch pending; o_mode_ready drops next cycle; go to WAIT_FRAME.
  - WAIT_FRAME: o_tg_en stays 1 until i_frame_end is sampled. Then o_tg_en=0 on the next cycle; go to CLK_REQ.
  - CLK_REQ: o_clk_sel=pending, o_clk_req=1 for exactly one cycle; clear the timeout counter; go to CLK_WAIT.
  - CLK_WAIT:
    - i_clk_ack sampled: timing outputs and o_cur_mode update to pending on the next cycle; clear the settle counter; go to SETTLE.
    - Timeout counter reaches P_ACK_TIMEOUT-1 with no ack: o_err pulse; return to CLK_REQ (unbounded retry).
  - SETTLE: count P_SETTLE_CYCLES cycles, then o_tg_en=1 and o_mode_ready=1; go to RUN.
- Timing, with ack sampled in cycle N:
  - Timing outputs change in cycle N+1.
  - o_tg_en rises in cycle N+1+P_SETTLE_CYCLES.
  - Timing outputs never change while o_tg_en=1.
- Request to clk_req latency from a RUN acceptance: frame-end cycle F gives o_tg_en=0 and o_clk_req=1 both in cycle F+1.
- i_clk_ack outside CLK_WAIT is ignored; i_frame_end outside WAIT_FRAME is ignored.
- Ack and timeout in the same cycle: ack wins, no o_err.
- Requests made while o_mode_ready=0 are not accepted; the requester holds valid.
- Reset mid-operation returns to the reset state: generator disabled, default mode re-requested.
- Counters are sized to clog2 of the parameter (minimum 1 bit) and never wrap in normal use.

Optional Feature:
Macro: VMC_FRAME_CNT_EN
- Defined: adds output o_frame_cnt [15:0].
  - Increments on each i_frame_end sampled while o_tg_en=1; wraps 0xFFFF->0.
  - Clears to 0 on reset and on the cycle o_cur_mode updates.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with P_DEFAULT_MODE=0, ack 3 cycles after o_clk_req -> single o_clk_req with o_clk_sel=0; outputs 640/480/16/96/48/10/2/33; o_tg_en rises 17 cycles after the ack cycle.
- In RUN, request mode 2, pulse i_frame_end 100 cycles later -> o_tg_en=0 and o_clk_req=1 in the same cycle after frame_end; after ack: 1920/1080/88/44/148/4/5/36, o_cur_mode=2.
- Request mode 3, then a request equal to o_cur_mode -> one o_err pulse for mode 3; no state change, no o_clk_req, o_tg_en stays 1 for both.
- Withhold ack with P_ACK_TIMEOUT=8 -> o_err pulse and new o_clk_req every 9 cycles; ack on the 3rd attempt completes the switch; ack coincident with timeout gives no o_err.
- Assert i_rst during SETTLE of a switch to mode 1 -> o_tg_en=0 next cycle; default mode re-requested; outputs revert to table[0].
- VMC_FRAME_CNT_EN: 5 frame_end pulses in RUN -> o_frame_cnt=5; after a mode switch -> 0; preload near 0xFFFF wraps to 0.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Run-time video mode controller: sequences the timing generator through stop, pixel-clock reconfig, reload and settle.
// Optional build macro VMC_FRAME_CNT_EN adds a 16-bit frame counter output (o_frame_cnt).
module video_mode_ctrl #(
    parameter int P_DEFAULT_MODE  = 0,
    parameter int P_SETTLE_CYCLES = 16,
    parameter int P_ACK_TIMEOUT   = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mode_valid,
    input  logic [1:0]  i_mode,
    output logic        o_mode_ready,
    input  logic        i_frame_end,
    output logic        o_tg_en,
    output logic [11:0] o_res_x,
    output logic [11:0] o_res_y,
    output logic [7:0]  o_hfront,
    output logic [7:0]  o_hsync,
    output logic [7:0]  o_hback,
    output logic [7:0]  o_vfront,
    output logic [7:0]  o_vsync,
    output logic [7:0]  o_vback,
    output logic [1:0]  o_clk_sel,
    output logic        o_clk_req,
    input  logic        i_clk_ack,
    output logic [1:0]  o_cur_mode,
    output logic        o_busy,
    output logic        o_err
`ifdef VMC_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int SETTLE_W = (P_SETTLE_CYCLES > 1) ? $clog2(P_SETTLE_CYCLES) : 1;
    localparam int ACK_W    = (P_ACK_TIMEOUT > 1) ? $clog2(P_ACK_TIMEOUT) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(P_SETTLE_CYCLES - 1);
    localparam logic [ACK_W-1:0]    ACK_LAST    = ACK_W'(P_ACK_TIMEOUT - 1);
    localparam logic [1:0]          DEF_MODE    = 2'(P_DEFAULT_MODE);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_CLK_REQ    = 3'd2,
        ST_CLK_WAIT   = 3'd3,
        ST_SETTLE     = 3'd4
    } state_t;

    typedef struct packed {
        logic [11:0] res_x;
        logic [11:0] res_y;
        logic [7:0]  hfront;
        logic [7:0]  hsync;
        logic [7:0]  hback;
        logic [7:0]  vfront;
        logic [7:0]  vsync;
        logic [7:0]  vback;
    } timing_t;

    function automatic timing_t mode_timing(input logic [1:0] mode);
        timing_t t;
        case (mode)
            2'd1:    t = '{12'd1280, 12'd720,  8'd110, 8'd40, 8'd220, 8'd5,  8'd5, 8'd20};
            2'd2:    t = '{12'd1920, 12'd1080, 8'd88,  8'd44, 8'd148, 8'd4,  8'd5, 8'd36};
            default: t = '{12'd640,  12'd480,  8'd16,  8'd96, 8'd48,  8'd10, 8'd2, 8'd33};
        endcase
        return t;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [1:0]            pending_r;
    logic [1:0]            pending_next_s;
    logic [1:0]            cur_mode_r;
    logic [1:0]            clk_sel_r;
    timing_t               timing_r;
    logic                  tg_en_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  clk_req_r;
    logic                  err_r;
    logic [ACK_W-1:0]      wait_cnt_r;
    logic [SETTLE_W-1:0]   settle_cnt_r;
    logic                  req_invalid_s;
    logic                  ack_take_s;
    logic                  timeout_s;
    logic                  issue_s;

    // Next-state decode; the frame-end path issues the clock request directly so the strobe lands with tg_en falling.
    always_comb begin
        state_next_s   = state_r;
        pending_next_s = pending_r;
        req_invalid_s  = 1'b0;
        ack_take_s     = 1'b0;
        timeout_s      = 1'b0;
        issue_s        = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_mode_valid && ready_r) begin
                    if (i_mode == 2'd3) begin
                        req_invalid_s = 1'b1;
                    end else if (i_mode == cur_mode_r) begin
                        state_next_s = ST_RUN;
                    end else begin
                        pending_next_s = i_mode;
                        state_next_s   = ST_WAIT_FRAME;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT_FRAME: begin
                if (i_frame_end) begin
                    issue_s      = 1'b1;
                    state_next_s = ST_CLK_WAIT;
                end else begin
                    state_next_s = ST_WAIT_FRAME;
                end
            end
            ST_CLK_REQ: begin
                issue_s      = 1'b1;
                state_next_s = ST_CLK_WAIT;
            end
            ST_CLK_WAIT: begin
                // Ack takes priority over a coincident timeout.
                if (i_clk_ack) begin
                    ack_take_s   = 1'b1;
                    state_next_s = ST_SETTLE;
                end else if (wait_cnt_r == ACK_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_CLK_REQ;
                end else begin
                    state_next_s = ST_CLK_WAIT;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            default: begin
                state_next_s = ST_CLK_REQ;
            end
        endcase
    end

    // State, pending mode and status outputs registered from the next-state decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_CLK_REQ;
            pending_r <= DEF_MODE;
            tg_en_r   <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
            clk_req_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
            tg_en_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_WAIT_FRAME);
            ready_r   <= (state_next_s == ST_RUN);
            busy_r    <= (state_next_s != ST_RUN);
            clk_req_r <= issue_s;
            err_r     <= req_invalid_s || timeout_s;
        end
    end

    // Clock select follows each request; timing and current mode change only on a taken ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sel_r  <= DEF_MODE;
            cur_mode_r <= DEF_MODE;
            timing_r   <= mode_timing(DEF_MODE);
        end else begin
            if (issue_s) begin
                clk_sel_r <= pending_r;
            end else begin
                clk_sel_r <= clk_sel_r;
            end
            if (ack_take_s) begin
                cur_mode_r <= pending_r;
                timing_r   <= mode_timing(pending_r);
            end else begin
                cur_mode_r <= cur_mode_r;
                timing_r   <= timing_r;
            end
        end
    end

    // Ack-timeout and settle counters run only while staying in their state, so they never wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt_r   <= '0;
            settle_cnt_r <= '0;
        end else begin
            if ((state_r == ST_CLK_WAIT) && (state_next_s == ST_CLK_WAIT)) begin
                wait_cnt_r <= wait_cnt_r + ACK_W'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            if ((state_r == ST_SETTLE) && (state_next_s == ST_SETTLE)) begin
                settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
            end else begin
                settle_cnt_r <= '0;
            end
        end
    end

`ifdef VMC_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frames shown in the current mode; restarts when a new mode is loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_r <= 16'd0;
        end else if (ack_take_s) begin
            frame_cnt_r <= 16'd0;
        end else if (i_frame_end && tg_en_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign o_frame_cnt = frame_cnt_r;
`endif

    assign o_mode_ready = ready_r;
    assign o_tg_en      = tg_en_r;
    assign o_res_x      = timing_r.res_x;
    assign o_res_y      = timing_r.res_y;
    assign o_hfront     = timing_r.hfront;
    assign o_hsync      = timing_r.hsync;
    assign o_hback      = timing_r.hback;
    assign o_vfront     = timing_r.vfront;
    assign o_vsync      = timing_r.vsync;
    assign o_vback      = timing_r.vback;
    assign o_clk_sel    = clk_sel_r;
    assign o_clk_req    = clk_req_r;
    assign o_cur_mode   = cur_mode_r;
    assign o_busy       = busy_r;
    assign o_err        = err_r;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: reset bring-up, mode switch, invalid/no-op requests, ack timeout retry, mid-switch reset.
module tb_video_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_valid;
    logic [1:0]  mode;
    logic        mode_ready;
    logic        frame_end;
    logic        tg_en;
    logic [11:0] res_x;
    logic [11:0] res_y;
    logic [7:0]  hfront, hsync, hback, vfront, vsync, vback;
    logic [1:0]  clk_sel;
    logic        clk_req;
    logic        clk_ack;
    logic [1:0]  cur_mode;
    logic        busy;
    logic        err;
`ifdef VMC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_mode_ctrl #(
        .P_DEFAULT_MODE (0),
        .P_SETTLE_CYCLES(16),
        .P_ACK_TIMEOUT  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode_valid(mode_valid),
        .i_mode      (mode),
        .o_mode_ready(mode_ready),
        .i_frame_end (frame_end),
        .o_tg_en     (tg_en),
        .o_res_x     (res_x),
        .o_res_y     (res_y),
        .o_hfront    (hfront),
        .o_hsync     (hsync),
        .o_hback     (hback),
        .o_vfront    (vfront),
        .o_vsync     (vsync),
        .o_vback     (vback),
        .o_clk_sel   (clk_sel),
        .o_clk_req   (clk_req),
        .i_clk_ack   (clk_ack),
        .o_cur_mode  (cur_mode),
        .o_busy      (busy),
        .o_err       (err)
`ifdef VMC_FRAME_CNT_EN
        ,
        .o_frame_cnt (frame_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_timing(input string tag, input int m);
        int ex [8];
        case (m)
            1:       ex = '{1280, 720, 110, 40, 220, 5, 5, 20};
            2:       ex = '{1920, 1080, 88, 44, 148, 4, 5, 36};
            default: ex = '{640, 480, 16, 96, 48, 10, 2, 33};
        endcase
        chk({tag, "_res_x"},  32'(res_x),  ex[0]);
        chk({tag, "_res_y"},  32'(res_y),  ex[1]);
        chk({tag, "_hfront"}, 32'(hfront), ex[2]);
        chk({tag, "_hsync"},  32'(hsync),  ex[3]);
        chk({tag, "_hback"},  32'(hback),  ex[4]);
        chk({tag, "_vfront"}, 32'(vfront), ex[5]);
        chk({tag, "_vsync"},  32'(vsync),  ex[6]);
        chk({tag, "_vback"},  32'(vback),  ex[7]);
        chk({tag, "_cur_mode"}, 32'(cur_mode), m);
    endtask

    // Called one cycle after the ack cycle N; tg_en must rise in N+17.
    task automatic settle(input string tag);
        repeat (15) tick();
        chk({tag, "_tg_hold"}, 32'(tg_en), 32'd0);
        chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_tg_rise"}, 32'(tg_en), 32'd1);
        chk({tag, "_ready"}, 32'(mode_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mode_valid = 1'b0; mode = 2'd0; frame_end = 1'b0; clk_ack = 1'b0;
        repeat (3) tick();
        chk("rst_tg_en", 32'(tg_en), 32'd0);
        chk("rst_ready", 32'(mode_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_clk_req", 32'(clk_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_clk_sel", 32'(clk_sel), 32'd0);
        chk_timing("rst", 0);

        // Bring-up: single request for the default mode, ack 3 cycles later.
        rst = 1'b0;
        tick();
        chk("boot_req", 32'(clk_req), 32'd1);
        chk("boot_sel", 32'(clk_sel), 32'd0);
        tick();
        chk("boot_req_single", 32'(clk_req), 32'd0);
        tick();
        tick();
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk_timing("boot", 0);
        chk("boot_tg_off", 32'(tg_en), 32'd0);
        settle("boot");

        // Stray ack in RUN is ignored.
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_tg", 32'(tg_en), 32'd1);

        // Switch to mode 2 with the frame end 100 cycles later.
        mode = 2'd2; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        chk("m2_ready_drop", 32'(mode_ready), 32'd0);
        chk("m2_tg_still_on", 32'(tg_en), 32'd1);
        chk("m2_busy", 32'(busy), 32'd1);
        repeat (99) tick();
        chk("m2_tg_before_fe", 32'(tg_en), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("m2_tg_off", 32'(tg_en), 32'd0);
        chk("m2_clk_req", 32'(clk_req), 32'd1);
        chk("m2_clk_sel", 32'(clk_sel), 32'd2);
        chk("m2_res_old", 32'(res_x), 32'd640);
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk_timing("m2", 2);
        settle("m2");

        // Invalid mode, then a request for the current mode.
        mode = 2'd3; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_tg", 32'(tg_en), 32'd1);
        chk("inv_ready", 32'(mode_ready), 32'd1);
        chk("inv_clk_req", 32'(clk_req), 32'd0);
        tick();
        chk("inv_err_pulse", 32'(err), 32'd0);
        mode = 2'd2; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        chk("same_err", 32'(err), 32'd0);
        chk("same_ready", 32'(mode_ready), 32'd1);
        chk("same_clk_req", 32'(clk_req), 32'd0);
        chk("same_tg", 32'(tg_en), 32'd1);
        tick();
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_mode", 32'(cur_mode), 32'd2);

        // Withheld ack: retry every 9 cycles; third attempt acked on its timeout cycle.
        mode = 2'd0; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("to_req1", 32'(clk_req), 32'd1);
        chk("to_sel", 32'(clk_sel), 32'd0);
        for (int a = 0; a < 2; a++) begin
            repeat (7) tick();
            chk($sformatf("to_noerr%0d", a), 32'(err), 32'd0);
            tick();
            chk($sformatf("to_err%0d", a), 32'(err), 32'd1);
            chk($sformatf("to_noreq%0d", a), 32'(clk_req), 32'd0);
            tick();
            chk($sformatf("to_rereq%0d", a), 32'(clk_req), 32'd1);
            chk($sformatf("to_errpulse%0d", a), 32'(err), 32'd0);
        end
        repeat (7) tick();
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk("to_ack_wins", 32'(err), 32'd0);
        chk("to_ack_noreq", 32'(clk_req), 32'd0);
        chk_timing("to", 0);
        settle("to");

        // Reset during the settle period of a switch to mode 1.
        mode = 2'd1; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("m1_clk_sel", 32'(clk_sel), 32'd1);
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk_timing("m1", 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_tg", 32'(tg_en), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd1);
        chk("mrst_ready", 32'(mode_ready), 32'd0);
        chk("mrst_sel", 32'(clk_sel), 32'd0);
        chk_timing("mrst", 0);
        tick();
        chk("mrst_req", 32'(clk_req), 32'd1);
        chk("mrst_req_sel", 32'(clk_sel), 32'd0);
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk("mrst_mode", 32'(cur_mode), 32'd0);
        settle("mrst");

`ifdef VMC_FRAME_CNT_EN
        chk("fc_start", 32'(frame_cnt), 32'd0);
        repeat (5) begin
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
            tick();
        end
        chk("fc_five", 32'(frame_cnt), 32'd5);
        mode = 2'd2; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("fc_six", 32'(frame_cnt), 32'd6);
        clk_ack = 1'b1;
        tick();
        clk_ack = 1'b0;
        chk("fc_clear", 32'(frame_cnt), 32'd0);
        settle("fc");
        frame_end = 1'b1;
        repeat (65535) tick();
        chk("fc_max", 32'(frame_cnt), 32'd65535);
        tick();
        frame_end = 1'b0;
        chk("fc_wrap", 32'(frame_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
